full_subtract: RTL and testbench

FULL_SUBTRACT -- requirements
Module: full_subtract

---
 rtl/full_subtract.sv | 41 ++++
 tb/tb_full_subtract.sv | 134 +++++++++++++
 2 files changed

// File: rtl/full_subtract.sv
// Registered WIDTH-bit subtractor built from a ripple-borrow chain of 1-bit full-subtract cells.
// Computes diff = a - b - borrowIn (mod 2^WIDTH) and the borrow out of the MSB, one clock late.
module full_subtract #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic [WIDTH-1:0] diff,
    output logic             borrowOut,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrowIn
);

    logic [WIDTH:0]   w_borrow;
    logic [WIDTH-1:0] w_diff;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_out;

    assign w_borrow[0] = borrowIn;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign w_diff[i]       = a[i] ^ b[i] ^ w_borrow[i];
        assign w_borrow[i + 1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_borrow[i]);
    end

    // Reset wins over capture; inputs on a reset edge are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
        end else begin
            r_diff       <= w_diff;
            r_borrow_out <= w_borrow[WIDTH];
        end
    end

    assign diff      = r_diff;
    assign borrowOut = r_borrow_out;

endmodule

// File: tb/tb_full_subtract.sv
// Self-checking bench for full_subtract at WIDTH 1, 8 and 64 against an arithmetic model.
module tb_full_subtract;

    logic        clk = 1'b0;
    logic        rst;
    logic [0:0]  a1, b1, d1;
    logic [7:0]  a8, b8, d8;
    logic [63:0] a64, b64, d64;
    logic        bi1, bi8, bi64, bo1, bo8, bo64;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    full_subtract #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .diff(d1), .borrowOut(bo1),
        .a(a1), .b(b1), .borrowIn(bi1)
    );
    full_subtract #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .diff(d8), .borrowOut(bo8),
        .a(a8), .b(b8), .borrowIn(bi8)
    );
    full_subtract #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst(rst), .diff(d64), .borrowOut(bo64),
        .a(a64), .b(b64), .borrowIn(bi64)
    );

    task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // {borrow, diff}: borrow iff a < b + bin as unbounded integers.
    function automatic logic [64:0] model(input logic [63:0] a, input logic [63:0] b,
                                          input logic bin, input int w);
        logic [63:0] mask;
        logic        borrow;
        mask   = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        borrow = ({1'b0, a} < ({1'b0, b} + 65'(bin)));
        return {borrow, (a - b - 64'(bin)) & mask};
    endfunction

    // Capture expectations from the current inputs, clock once, then check all widths.
    task automatic tick(input string tag);
        logic [64:0] e1, e8, e64;
        e1  = rst ? '0 : model(64'(a1), 64'(b1), bi1, 1);
        e8  = rst ? '0 : model(64'(a8), 64'(b8), bi8, 8);
        e64 = rst ? '0 : model(a64, b64, bi64, 64);
        @(posedge clk);
        #1;
        check({tag, "/w1"},  {bo1, 63'd0, d1}, {e1[64], 63'd0, e1[0]});
        check({tag, "/w8"},  {bo8, 56'd0, d8}, {e8[64], 56'd0, e8[7:0]});
        check({tag, "/w64"}, {bo64, d64}, e64);
    endtask

    task automatic randomize_inputs();
        a1   = 1'($urandom);
        b1   = 1'($urandom);
        bi1  = 1'($urandom);
        a8   = 8'($urandom);
        b8   = 8'($urandom);
        bi8  = 1'($urandom);
        a64  = {$urandom, $urandom};
        b64  = {$urandom, $urandom};
        bi64 = 1'($urandom);
    endtask

    initial begin
        rst = 1'b1;
        randomize_inputs();
        tick("reset");
        randomize_inputs();
        tick("reset_hold");
        rst = 1'b0;

        a1 = 1'b1; b1 = 1'b1; bi1 = 1'b0;
        a8 = 8'h00; b8 = 8'h01; bi8 = 1'b0;
        a64 = 64'd7; b64 = 64'd7; bi64 = 1'b0;
        tick("dir1");
        check("w1_eq", {bo1, d1}, 2'b00);
        check("w8_under", {bo8, d8}, {1'b1, 8'hFF});
        check("w64_eq", {bo64, d64}, 65'd0);

        a1 = 1'b0; b1 = 1'b1; bi1 = 1'b0;
        a8 = 8'h80; b8 = 8'h7F; bi8 = 1'b1;
        a64 = 64'd9; b64 = 64'd9; bi64 = 1'b1;
        tick("dir2");
        check("w1_under", {bo1, d1}, 2'b11);
        check("w8_exact", {bo8, d8}, {1'b0, 8'h00});
        check("w64_eq_bin", {bo64, d64}, {1'b1, {64{1'b1}}});

        a1 = 1'b1; b1 = 1'b0; bi1 = 1'b0;
        a64 = 64'd0; b64 = '1; bi64 = 1'b1;
        tick("dir3");
        check("w1_pos", {bo1, d1}, 2'b01);
        check("w64_wrap", {bo64, d64}, {1'b1, 64'd0});

        // Exhaustive 1-bit truth table.
        for (int i = 0; i < 8; i++) begin
            a1  = 1'(i >> 2);
            b1  = 1'(i >> 1);
            bi1 = 1'(i);
            tick("truth");
        end

        // Reset with outputs holding FF/1, then release.
        a8 = 8'h00; b8 = 8'h01; bi8 = 1'b0;
        tick("pre_rst");
        check("w8_ff", {bo8, d8}, {1'b1, 8'hFF});
        rst = 1'b1; a8 = 8'h05; b8 = 8'h03; bi8 = 1'b0;
        tick("mid_rst");
        check("w8_rst", {bo8, d8}, 9'd0);
        rst = 1'b0;
        tick("post_rst");
        check("w8_after", {bo8, d8}, {1'b0, 8'h02});

        for (int n = 0; n < 1000; n++) begin
            randomize_inputs();
            if (n % 7 == 0) begin
                b8  = a8;
                b64 = a64;
            end
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
